dsd7_mmu_arbiter: RTL and testbench

DSD7_MMU_ARBITER -- requirements
Module: dsd7_mmu_arbiter

---
 rtl/dsd7_mmu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dsd7_mmu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsd7_mmu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dsd7_mmu_arbiter
// Brief    : Two-master (instruction fetch / data) arbiter in front of the MMU
//            slave port. Alternating tie-break, stall timeout with bus error,
//            and a release phase that waits for the slave handshake to drop.
// Revision : 1.0 - initial release
// ============================================================================
module dsd7_mmu_arbiter #(
    parameter int unsigned TMO = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // master 0 : instruction fetch
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_vpa_i,
    input  logic        m0_vda_i,
    input  logic        m0_wr_i,
    input  logic [1:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_sr_i,
    input  logic        m0_cr_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rb_o,
    output logic [31:0] m0_dat_o,
    // master 1 : data
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_vpa_i,
    input  logic        m1_vda_i,
    input  logic        m1_wr_i,
    input  logic [1:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_sr_i,
    input  logic        m1_cr_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rb_o,
    output logic [31:0] m1_dat_o,
    // MMU slave side
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_vpa_o,
    output logic        s_vda_o,
    output logic        s_wr_o,
    output logic        s_sr_o,
    output logic        s_cr_o,
    output logic [1:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic        s_rb_i,
    input  logic [31:0] s_dat_i
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY    = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;
    localparam logic [7:0] c_TMO     = TMO[7:0];

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_owner;   // 0 = m0, 1 = m1
    logic       r_lo;      // last owner, used to alternate on ties
    logic [7:0] r_tc;      // consecutive stall cycles
    logic       r_err;     // timeout latched until owner drops stb

    logic w_busy;
    logic w_own_cyc;
    logic w_own_stb;
    logic w_err;
    logic w_m0;
    logic w_m1;

    assign w_busy    = (r_state == c_BUSY);
    assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;
    assign w_own_stb = r_owner ? m1_stb_i : m0_stb_i;
    // The timeout is visible in the very cycle tc reaches TMO, then held by r_err.
    assign w_err     = w_busy & (r_err | (r_tc == c_TMO));
    assign w_m0      = w_busy & ~r_owner;
    assign w_m1      = w_busy &  r_owner;

    // Slave request: owner's signals passed straight through while BUSY, else 0.
    assign s_cyc_o = w_busy & w_own_cyc;
    assign s_stb_o = w_busy & w_own_stb & ~w_err;
    assign s_vpa_o = w_busy & (r_owner ? m1_vpa_i : m0_vpa_i);
    assign s_vda_o = w_busy & (r_owner ? m1_vda_i : m0_vda_i);
    assign s_wr_o  = w_busy & (r_owner ? m1_wr_i  : m0_wr_i);
    assign s_sr_o  = w_busy & (r_owner ? m1_sr_i  : m0_sr_i);
    assign s_cr_o  = w_busy & (r_owner ? m1_cr_i  : m0_cr_i);
    assign s_sel_o = w_busy ? (r_owner ? m1_sel_i : m0_sel_i) : 2'b00;
    assign s_adr_o = w_busy ? (r_owner ? m1_adr_i : m0_adr_i) : 32'd0;
    assign s_dat_o = w_busy ? (r_owner ? m1_dat_i : m0_dat_i) : 32'd0;

    // Responses go to the owner only; err wins over ack.
    assign m0_ack_o = w_m0 & s_ack_i & ~w_err;
    assign m0_err_o = w_m0 & w_err;
    assign m0_rb_o  = w_m0 & s_rb_i;
    assign m0_dat_o = w_m0 ? s_dat_i : 32'd0;
    assign m1_ack_o = w_m1 & s_ack_i & ~w_err;
    assign m1_err_o = w_m1 & w_err;
    assign m1_rb_o  = w_m1 & s_rb_i;
    assign m1_dat_o = w_m1 ? s_dat_i : 32'd0;

    // Next-state logic of the arbitration FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (m0_cyc_i | m1_cyc_i) w_state_nxt = c_BUSY;
            c_BUSY:    if (!w_own_cyc)          w_state_nxt = c_RELEASE;
            c_RELEASE: if (!s_ack_i)            w_state_nxt = c_IDLE;
            default:                            w_state_nxt = c_IDLE;
        endcase
    end

    // State register plus owner selection, stall counter and error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_owner <= 1'b0;
            r_lo    <= 1'b1;
            r_tc    <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_IDLE: begin
                    r_tc  <= 8'd0;
                    r_err <= 1'b0;
                    if (m0_cyc_i & m1_cyc_i) r_owner <= ~r_lo;
                    else if (m1_cyc_i)       r_owner <= 1'b1;
                    else if (m0_cyc_i)       r_owner <= 1'b0;
                end
                c_BUSY: begin
                    if (!w_own_cyc) begin
                        r_lo  <= r_owner;
                        r_tc  <= 8'd0;
                        r_err <= 1'b0;
                    end else if (w_err) begin
                        r_tc  <= 8'd0;
                        r_err <= w_own_stb;
                    end else if (s_stb_o & ~s_ack_i) begin
                        r_tc  <= r_tc + 8'd1;
                    end else begin
                        r_tc  <= 8'd0;
                    end
                end
                default: begin
                    r_tc  <= 8'd0;
                    r_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsd7_mmu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsd7_mmu_arbiter
// Brief    : Directed self-checking bench for dsd7_mmu_arbiter (TMO = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsd7_mmu_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_vpa_i, m0_vda_i, m0_wr_i, m0_sr_i, m0_cr_i;
    logic [1:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o, m0_err_o, m0_rb_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_vpa_i, m1_vda_i, m1_wr_i, m1_sr_i, m1_cr_i;
    logic [1:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o, m1_err_o, m1_rb_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_vpa_o, s_vda_o, s_wr_o, s_sr_o, s_cr_o;
    logic [1:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i, s_rb_i;
    logic [31:0] s_dat_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    dsd7_mmu_arbiter #(.TMO(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_vpa_i(m0_vpa_i), .m0_vda_i(m0_vda_i),
        .m0_wr_i(m0_wr_i), .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_sr_i(m0_sr_i), .m0_cr_i(m0_cr_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_rb_o(m0_rb_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_vpa_i(m1_vpa_i), .m1_vda_i(m1_vda_i),
        .m1_wr_i(m1_wr_i), .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_sr_i(m1_sr_i), .m1_cr_i(m1_cr_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_rb_o(m1_rb_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_vpa_o(s_vpa_o), .s_vda_o(s_vda_o),
        .s_wr_o(s_wr_o), .s_sr_o(s_sr_o), .s_cr_o(s_cr_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_rb_i(s_rb_i), .s_dat_i(s_dat_i)
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        {m0_cyc_i, m0_stb_i, m0_vpa_i, m0_vda_i, m0_wr_i, m0_sr_i, m0_cr_i} = '0;
        {m1_cyc_i, m1_stb_i, m1_vpa_i, m1_vda_i, m1_wr_i, m1_sr_i, m1_cr_i} = '0;
        m0_sel_i = 2'b00; m1_sel_i = 2'b00;
        m0_adr_i = 32'h0000_1000; m1_adr_i = 32'h0000_2000;
        m0_dat_i = 32'h0; m1_dat_i = 32'h0;
        s_ack_i = 1'b0; s_rb_i = 1'b0; s_dat_i = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1;
        tick(); tick();
        n_checks++;
        if ({s_cyc_o, s_stb_o, s_adr_o, m0_ack_o, m0_err_o, m1_ack_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: s_cyc=%b s_stb=%b s_adr=%h m0_ack=%b m0_err=%b m1_ack=%b, required all 0",
                     s_cyc_o, s_stb_o, s_adr_o, m0_ack_o, m0_err_o, m1_ack_o);
        end
        clear_inputs();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_vpa_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_vda_i = 1'b1;
        #1;
        n_checks++;
        if (s_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL tie_idle_cyc: s_cyc=%b, required 0", s_cyc_o);
        end
        tick();
        n_checks++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_1000 || s_vpa_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_grant_m0: s_cyc=%b s_adr=%h s_vpa=%b, required 1 00001000 1", s_cyc_o, s_adr_o, s_vpa_o);
        end
        s_ack_i = 1'b1; s_dat_i = 32'h1234_5678; #1;
        n_checks++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m0_dat_o !== 32'h1234_5678 || m1_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL tie_ack_m0: m0_ack=%b m1_ack=%b m0_dat=%h m1_dat=%h, required 1 0 12345678 00000000",
                     m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o);
        end
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0; #1;
        n_checks++;
        if (s_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL tie_m0_drop: s_cyc=%b, required 0", s_cyc_o);
        end
        tick(); tick(); tick();   // BUSY->RELEASE->IDLE->BUSY(m1)
        n_checks++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_2000 || s_vda_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_grant_m1: s_cyc=%b s_adr=%h s_vda=%b, required 1 00002000 1", s_cyc_o, s_adr_o, s_vda_o);
        end
        s_ack_i = 1'b1; #1;
        n_checks++;
        if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL tie_ack_m1: m1_ack=%b m0_ack=%b, required 1 0", m1_ack_o, m0_ack_o);
        end
        tick();
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_alternate();
        logic [31:0] exp_adr;
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // first tie after reset to m0, then m1,m0,m1,m0
            exp_adr = (i % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000;
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
            tick();
            n_checks++;
            if (s_cyc_o !== 1'b1 || s_adr_o !== exp_adr) begin
                n_fail++;
                $display("FAIL alternate_grant[%0d]: s_cyc=%b s_adr=%h, required 1 %h", i, s_cyc_o, s_adr_o, exp_adr);
            end
            s_ack_i = 1'b1; #1;
            n_checks++;
            if (m0_ack_o !== (i % 2 == 0) || m1_ack_o !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL alternate_ack[%0d]: m0_ack=%b m1_ack=%b, required %b %b",
                         i, m0_ack_o, m1_ack_o, (i % 2 == 0), (i % 2 == 1));
            end
            tick();
            clear_inputs();
            tick(); tick();
        end
    endtask

    task automatic test_write();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_wr_i = 1'b1; m1_sel_i = 2'b11;
        m1_dat_i = 32'hDEAD_BEEF; m1_adr_i = 32'h0000_3000; m1_sr_i = 1'b1;
        tick();
        n_checks++;
        if (s_wr_o !== 1'b1 || s_dat_o !== 32'hDEAD_BEEF || s_sel_o !== 2'b11 ||
            s_adr_o !== 32'h0000_3000 || s_sr_o !== 1'b1 || s_cr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL write_passthru: wr=%b dat=%h sel=%b adr=%h sr=%b cr=%b, required 1 deadbeef 11 00003000 1 0",
                     s_wr_o, s_dat_o, s_sel_o, s_adr_o, s_sr_o, s_cr_o);
        end
        n_checks++;
        if (m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL write_no_ack: m1_ack=%b m0_ack=%b, required 0 0", m1_ack_o, m0_ack_o);
        end
        s_ack_i = 1'b1; s_rb_i = 1'b1; #1;
        n_checks++;
        if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_rb_o !== 1'b1 || m0_rb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ack: m1_ack=%b m0_ack=%b m1_rb=%b m0_rb=%b, required 1 0 1 0",
                     m1_ack_o, m0_ack_o, m1_rb_o, m0_rb_o);
        end
        tick();
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_timeout();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();   // stall cycle 1
        for (int i = 2; i <= 4; i++) begin
            tick();
        end
        n_checks++;
        if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
            n_fail++; $display("FAIL timeout_4th: m0_err=%b s_stb=%b, required 0 1", m0_err_o, s_stb_o);
        end
        tick();   // stall cycle 5
        s_ack_i = 1'b1; #1;
        n_checks++;
        if (m0_err_o !== 1'b1 || s_stb_o !== 1'b0 || m0_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_5th: m0_err=%b s_stb=%b m0_ack=%b m1_err=%b, required 1 0 0 0",
                     m0_err_o, s_stb_o, m0_ack_o, m1_err_o);
        end
        s_ack_i = 1'b0;
        tick();
        n_checks++;
        if (m0_err_o !== 1'b1 || s_stb_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_held: m0_err=%b s_stb=%b, required 1 0", m0_err_o, s_stb_o);
        end
        m0_stb_i = 1'b0;
        tick();
        m0_stb_i = 1'b1; #1;
        n_checks++;
        if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1 || s_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_cleared: m0_err=%b s_stb=%b s_cyc=%b, required 0 1 1", m0_err_o, s_stb_o, s_cyc_o);
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_release_hold();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        s_ack_i = 1'b1;
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();   // now RELEASE, slave ack still high
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick(); tick();
        n_checks++;
        if (s_cyc_o !== 1'b0 || m1_ack_o !== 1'b0 || s_adr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL release_hold: s_cyc=%b m1_ack=%b s_adr=%h, required 0 0 00000000", s_cyc_o, m1_ack_o, s_adr_o);
        end
        s_ack_i = 1'b0;
        tick();   // IDLE
        n_checks++;
        if (s_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL release_idle: s_cyc=%b, required 0", s_cyc_o);
        end
        tick();   // BUSY, m1
        n_checks++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_2000) begin
            n_fail++; $display("FAIL release_regrant: s_cyc=%b s_adr=%h, required 1 00002000", s_cyc_o, s_adr_o);
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        s_ack_i = 1'b1; #1;
        n_checks++;
        if (m1_ack_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre_ack: m1_ack=%b, required 1", m1_ack_o);
        end
        rst_i = 1'b1;
        tick();
        n_checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m1_ack_o !== 1'b0 || m1_err_o !== 1'b0 || m1_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: s_cyc=%b s_stb=%b m1_ack=%b m1_err=%b m1_dat=%h, required all 0",
                     s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, m1_dat_o);
        end
        rst_i = 1'b0; s_ack_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        n_checks++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_1000) begin
            n_fail++; $display("FAIL rstmid_tie_m0: s_cyc=%b s_adr=%h, required 1 00001000", s_cyc_o, s_adr_o);
        end
        clear_inputs();
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_alternate();
        test_write();
        test_timeout();
        test_release_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
